audio_sample_ring_writer: RTL

- Avalon-MM write master that sits directly upstream of the on-chip sample memory (32-bit data, 16-bit word address, byteenable, single port).
- Accepts a push-only stream of 32-bit audio samples from the codec interface.
- Buffers samples in a small FIFO and writes them into a circular region of that memory.
- Reports the write pointer and wrap events so the Nios visualiser software knows which samples are fresh.

---
 rtl/audio_sample_ring_writer_if.sv | 33 +++
 rtl/audio_sample_ring_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_ring_writer_if.sv
// Bus bundle for the ring writer: codec sample stream in, Avalon-MM write out.
//
// Handshake semantics:
//   snk_*  : push-only. A sample transfers on every clock edge where
//            snk_valid=1; there is no ready/backpressure path.
//   avm_*  : a write transfers on a clock edge where avm_write=1 and
//            avm_waitrequest=0. While avm_waitrequest=1 the master holds
//            address, data, byteenable and write/chipselect unchanged.
interface audio_sample_ring_writer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   snk_data;
    logic                snk_valid;
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic                avm_waitrequest;

    // Ring writer side
    modport master (
        input  snk_data, snk_valid, avm_waitrequest,
        output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata
    );

    // Codec / memory side
    modport slave (
        output snk_data, snk_valid, avm_waitrequest,
        input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata
    );
endinterface

// File: rtl/audio_sample_ring_writer.sv
// Audio sample ring writer: buffers codec samples in a small FIFO and writes
// them as single-word Avalon-MM writes into a circular region of memory.
module audio_sample_ring_writer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    buf_words,
    audio_sample_ring_writer_if.master bus,
    output logic [ADDR_W-1:0]    wr_ptr,
    output logic                 wrap_pulse,
    output logic [15:0]          overflow_cnt,
    output logic                 cfg_err,
    output logic                 busy,
    output logic                 dbg_state
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int BE_W  = DATA_W / 8;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_en_d;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_len;
    logic                r_cfg_err;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic                r_wrap;
    logic [15:0]         r_ovf;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [IDX_W-1:0]    r_rd_idx;
    logic [IDX_W-1:0]    r_wr_idx;
    logic [CNT_W-1:0]    r_count;

    logic                r_avm_write;
    logic [ADDR_W-1:0]   r_avm_addr;
    logic [DATA_W-1:0]   r_avm_data;
    logic [BE_W-1:0]     r_avm_be;

    logic                w_en_rise;
    logic                w_cfg_err_now;
    logic                w_run;
    logic                w_in_write;
    logic                w_complete;
    logic                w_pop;
    logic                w_flush;
    logic                w_full;
    logic                w_push_req;
    logic                w_push;
    logic                w_drop;
    logic                w_last;
    logic [ADDR_W-1:0]   w_ptr_adv;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic [ADDR_W-1:0]   w_base_nxt;
    logic [IDX_W-1:0]    w_rd_nxt;

    logic                w_avm_write_nxt;
    logic [ADDR_W-1:0]   w_avm_addr_nxt;
    logic [DATA_W-1:0]   w_avm_data_nxt;
    logic [BE_W-1:0]     w_avm_be_nxt;

    // A rise both latches config and takes effect in the same cycle, so the
    // error flag used for gating looks ahead at the value being latched.
    assign w_en_rise     = enable & ~r_en_d;
    assign w_cfg_err_now = w_en_rise ? (buf_words == '0) : r_cfg_err;
    assign w_run         = enable & ~w_cfg_err_now;

    assign w_in_write = (r_state == S_WRITE);
    assign w_complete = w_in_write & ~bus.avm_waitrequest;
    assign w_pop      = w_complete;
    // Once stopped, the FIFO is discarded, but never under a held write.
    assign w_flush    = ~w_run & (~w_in_write | w_complete);

    assign w_full     = (r_count == FULL_CNT);
    assign w_push_req = w_run & bus.snk_valid;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    assign w_last     = (r_wr_ptr == r_len - ADDR_W'(1));
    assign w_ptr_adv  = w_last ? '0 : r_wr_ptr + ADDR_W'(1);
    assign w_ptr_nxt  = w_en_rise ? '0 : (w_complete ? w_ptr_adv : r_wr_ptr);
    assign w_base_nxt = w_en_rise ? base_addr : r_base;
    assign w_rd_nxt   = w_pop ? r_rd_idx + IDX_W'(1) : r_rd_idx;

    // Config latch, ring pointer, wrap strobe and overflow counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en_d    <= 1'b0;
            r_base    <= '0;
            r_len     <= '0;
            r_cfg_err <= 1'b0;
            r_wr_ptr  <= '0;
            r_wrap    <= 1'b0;
            r_ovf     <= '0;
        end else begin
            r_en_d   <= enable;
            r_wr_ptr <= w_ptr_nxt;
            r_wrap   <= w_complete & w_last;
            if (w_en_rise) begin
                r_base    <= base_addr;
                r_len     <= buf_words;
                r_cfg_err <= (buf_words == '0);
                r_ovf     <= '0;
            end else if (w_drop && r_ovf != 16'hFFFF) begin
                r_ovf <= r_ovf + 16'd1;
            end
        end
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_idx] <= bus.snk_data;
        end
    end

    // FIFO indices and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_idx <= '0;
            r_wr_idx <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_idx <= r_wr_idx;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_idx <= r_wr_idx + IDX_W'(1);
            if (w_pop)  r_rd_idx <= r_rd_idx + IDX_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next-state: keep writing back to back while more samples are queued
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_run && r_count != '0) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (w_complete) begin
                    w_state_nxt = (w_run && r_count > CNT_W'(1)) ? S_WRITE : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: next values for the registered Avalon signals, frozen under waitrequest
    always_comb begin
        w_avm_write_nxt = r_avm_write;
        w_avm_addr_nxt  = r_avm_addr;
        w_avm_data_nxt  = r_avm_data;
        w_avm_be_nxt    = r_avm_be;
        if (!(w_in_write && bus.avm_waitrequest)) begin
            w_avm_write_nxt = (w_state_nxt == S_WRITE);
            w_avm_addr_nxt  = w_avm_write_nxt ? (w_base_nxt + w_ptr_nxt) : '0;
            w_avm_data_nxt  = w_avm_write_nxt ? r_mem[w_rd_nxt] : '0;
            w_avm_be_nxt    = w_avm_write_nxt ? '1 : '0;
        end
    end

    // Avalon output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_avm_write <= 1'b0;
            r_avm_addr  <= '0;
            r_avm_data  <= '0;
            r_avm_be    <= '0;
        end else begin
            r_avm_write <= w_avm_write_nxt;
            r_avm_addr  <= w_avm_addr_nxt;
            r_avm_data  <= w_avm_data_nxt;
            r_avm_be    <= w_avm_be_nxt;
        end
    end

    assign bus.avm_write      = r_avm_write;
    assign bus.avm_chipselect = r_avm_write;
    assign bus.avm_address    = r_avm_addr;
    assign bus.avm_writedata  = r_avm_data;
    assign bus.avm_byteenable = r_avm_be;

    assign wr_ptr       = r_wr_ptr;
    assign wrap_pulse   = r_wrap;
    assign overflow_cnt = r_ovf;
    assign cfg_err      = r_cfg_err;
    assign busy         = w_in_write | (r_count != '0);
    assign dbg_state    = r_state;

endmodule
